// File: rtl/dds_update_scheduler_pkg.sv
// Shared DDS definitions: register map, CSR channel codes, frame kinds and frame builders.
// All frames are left-aligned in FRAME_BITS and sent MSB first.
package dds_pkg;

   localparam int FRAME_BITS = 176;

   localparam logic [4:0] REG_CSR  = 5'h00;
   localparam logic [4:0] REG_CFR  = 5'h03;
   localparam logic [4:0] REG_FTW0 = 5'h04;
   localparam logic [4:0] REG_ACR  = 5'h06;

   localparam logic [1:0] CSR_CH0       = 2'b01;
   localparam logic [1:0] CSR_CH1       = 2'b10;
   localparam logic [5:0] CSR_MODE_4BIT = 6'b000110;
   localparam logic [5:0] ACR_HI_BITS   = 6'b000100;

   localparam logic [4:0] POINT_FRAME_BYTES = 5'd22;

   typedef enum logic [1:0] {
      KIND_BLANK  = 2'd0,
      KIND_POINT  = 2'd1,
      KIND_CONFIG = 2'd2,
      KIND_HOLD   = 2'd3
   } frame_kind_t;

   typedef struct packed {
      logic [31:0] f0;
      logic [31:0] f1;
      logic [9:0]  a0;
      logic [9:0]  a1;
   } point_t;

   // One channel: CSR select, FTW0 write, ACR write (11 bytes).
   function automatic logic [87:0] build_channel(input logic [1:0] ch, input logic [31:0] f,
                                                 input logic [9:0] a);
      return {3'b000, REG_CSR, ch, CSR_MODE_4BIT,
              3'b000, REG_FTW0, f,
              3'b000, REG_ACR, 8'h00, ACR_HI_BITS, a};
   endfunction

   function automatic logic [FRAME_BITS-1:0] build_point_frame(input logic [31:0] f0,
                                                              input logic [31:0] f1,
                                                              input logic [9:0]  a0,
                                                              input logic [9:0]  a1);
      return {build_channel(CSR_CH0, f0, a0), build_channel(CSR_CH1, f1, a1)};
   endfunction

   // Out-of-range byte counts fall back to a full 32-bit payload.
   function automatic logic [2:0] cfg_len(input logic [2:0] n);
      return (n == 3'd0 || n > 3'd4) ? 3'd4 : n;
   endfunction

   function automatic logic [4:0] cfg_frame_bytes(input logic [2:0] n);
      return 5'd3 + {2'b00, cfg_len(n)};
   endfunction

   function automatic logic [FRAME_BITS-1:0] build_cfg_frame(input logic [1:0]  ch,
                                                            input logic [4:0]  addr,
                                                            input logic [31:0] data,
                                                            input logic [2:0]  n);
      logic [FRAME_BITS-1:0] r;
      logic [2:0]            len;
      r   = '0;
      len = cfg_len(n);
      r[FRAME_BITS-1 -: 24] = {3'b000, REG_CSR, ch, CSR_MODE_4BIT, 3'b000, addr};
      for (int i = 0; i < 4; i++) begin
         if (i < int'(len)) begin
            r[FRAME_BITS-25-8*i -: 8] = data[31-8*i -: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dds_update_scheduler_if.sv
// Point stream, register-write port and frame output of the DDS update scheduler.
// The scheduler is the slave; the vector unit / host / serializer side is the master.
interface dds_update_scheduler_if;
   import dds_pkg::*;

   logic                  dds_ready;
   logic                  slot;
   logic [FRAME_BITS-1:0] frame;
   logic [4:0]            frame_bytes;
   logic [1:0]            frame_kind;

   logic                  pt_valid;
   logic                  pt_ready;
   logic [31:0]           pt_f0;
   logic [31:0]           pt_f1;
   logic [9:0]            pt_a0;
   logic [9:0]            pt_a1;

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [1:0]            cfg_ch;
   logic [4:0]            cfg_addr;
   logic [31:0]           cfg_data;
   logic [2:0]            cfg_nbytes;

   logic                  blanked;
   logic [15:0]           underrun_cnt;

   modport master (
      output dds_ready, slot,
      output pt_valid, pt_f0, pt_f1, pt_a0, pt_a1,
      output cfg_valid, cfg_ch, cfg_addr, cfg_data, cfg_nbytes,
      input  frame, frame_bytes, frame_kind, pt_ready, cfg_ready, blanked, underrun_cnt
   );

   modport slave (
      input  dds_ready, slot,
      input  pt_valid, pt_f0, pt_f1, pt_a0, pt_a1,
      input  cfg_valid, cfg_ch, cfg_addr, cfg_data, cfg_nbytes,
      output frame, frame_bytes, frame_kind, pt_ready, cfg_ready, blanked, underrun_cnt
   );

endinterface

// File: rtl/dds_update_scheduler_point_fifo.sv
// Synchronous point FIFO; pointers carry one extra wrap bit to tell full from empty.
// Head entry is read combinationally so the arbiter can use it in the slot cycle.
module dds_point_fifo
   import dds_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push_valid,
   input  point_t push_data,
   output logic   push_ready,
   input  logic   pop,
   output point_t pop_data,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_reg, wr_ptr_next;
   logic [AW:0] rd_ptr_reg, rd_ptr_next;
   logic        push_ready_reg;
   logic        do_push;
   logic        do_pop;
   logic        full_next;
   point_t      mem [DEPTH];

   assign empty       = (wr_ptr_reg == rd_ptr_reg);
   assign do_push     = push_valid & push_ready_reg;
   assign do_pop      = pop & ~empty;
   assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, do_push};
   assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};
   assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                        (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

   // Ready is registered, so a push offered while full is refused even if a pop frees a slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         push_ready_reg <= 1'b1;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         push_ready_reg <= ~full_next;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   assign pop_data   = mem[rd_ptr_reg[AW-1:0]];
   assign push_ready = push_ready_reg;

endmodule

// File: rtl/dds_update_scheduler.sv
// Chooses the frame the DDS serializer sends on each slot: config writes, buffered points,
// or hold-then-blank when the point stream underruns.
module dds_update_scheduler
   import dds_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int MAX_CFG_RUN = 2,
   parameter int HOLD_LIMIT  = 64
) (
   input logic                   clk,
   input logic                   reset,
   dds_update_scheduler_if.slave bus
);

   localparam int CW = $clog2(MAX_CFG_RUN + 2);
   localparam int HW = $clog2(HOLD_LIMIT + 2);

   typedef enum logic {ST_WAIT, ST_RUN} state_t;

   state_t                state_reg, state_next;
   logic [FRAME_BITS-1:0] frame_reg, frame_next;
   logic [4:0]            frame_bytes_reg, frame_bytes_next;
   frame_kind_t           frame_kind_reg, frame_kind_next;
   logic [CW-1:0]         cfg_run_reg, cfg_run_next;
   logic [HW-1:0]         hold_cnt_reg, hold_cnt_next;
   logic [15:0]           underrun_reg, underrun_next;
   point_t                last_pt_reg, last_pt_next;

   logic                  cfg_grant;
   logic                  fifo_pop;
   logic                  fifo_empty;
   point_t                fifo_head;
   point_t                push_data;

   assign push_data = '{f0: bus.pt_f0, f1: bus.pt_f1, a0: bus.pt_a0, a1: bus.pt_a1};

   dds_point_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (bus.pt_valid),
      .push_data  (push_data),
      .push_ready (bus.pt_ready),
      .pop        (fifo_pop),
      .pop_data   (fifo_head),
      .empty      (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_WAIT;
         frame_reg       <= build_point_frame('0, '0, '0, '0);
         frame_bytes_reg <= POINT_FRAME_BYTES;
         frame_kind_reg  <= KIND_BLANK;
         cfg_run_reg     <= '0;
         hold_cnt_reg    <= '0;
         underrun_reg    <= '0;
         last_pt_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         frame_reg       <= frame_next;
         frame_bytes_reg <= frame_bytes_next;
         frame_kind_reg  <= frame_kind_next;
         cfg_run_reg     <= cfg_run_next;
         hold_cnt_reg    <= hold_cnt_next;
         underrun_reg    <= underrun_next;
         last_pt_reg     <= last_pt_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      frame_next       = frame_reg;
      frame_bytes_next = frame_bytes_reg;
      frame_kind_next  = frame_kind_reg;
      cfg_run_next     = cfg_run_reg;
      hold_cnt_next    = hold_cnt_reg;
      underrun_next    = underrun_reg;
      last_pt_next     = last_pt_reg;
      cfg_grant        = 1'b0;
      fifo_pop         = 1'b0;

      case (state_reg)
         ST_WAIT: begin
            if (bus.dds_ready) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!bus.dds_ready) begin
               state_next = ST_WAIT;
            end
            if (bus.slot) begin
               // Config bursts may starve points only up to MAX_CFG_RUN frames in a row.
               if (bus.cfg_valid && (fifo_empty || cfg_run_reg < CW'(MAX_CFG_RUN))) begin
                  cfg_grant        = 1'b1;
                  frame_next       = build_cfg_frame(bus.cfg_ch, bus.cfg_addr, bus.cfg_data,
                                                     bus.cfg_nbytes);
                  frame_bytes_next = cfg_frame_bytes(bus.cfg_nbytes);
                  frame_kind_next  = KIND_CONFIG;
                  if (cfg_run_reg < CW'(MAX_CFG_RUN)) begin
                     cfg_run_next = cfg_run_reg + CW'(1);
                  end
               end else if (!fifo_empty) begin
                  fifo_pop         = 1'b1;
                  last_pt_next     = fifo_head;
                  frame_next       = build_point_frame(fifo_head.f0, fifo_head.f1,
                                                       fifo_head.a0, fifo_head.a1);
                  frame_bytes_next = POINT_FRAME_BYTES;
                  frame_kind_next  = KIND_POINT;
                  cfg_run_next     = '0;
                  hold_cnt_next    = '0;
               end else begin
                  frame_bytes_next = POINT_FRAME_BYTES;
                  if (underrun_reg != 16'hFFFF) begin
                     underrun_next = underrun_reg + 16'd1;
                  end
                  if (hold_cnt_reg < HW'(HOLD_LIMIT)) begin
                     frame_next      = build_point_frame(last_pt_reg.f0, last_pt_reg.f1,
                                                         last_pt_reg.a0, last_pt_reg.a1);
                     frame_kind_next = KIND_HOLD;
                     hold_cnt_next   = hold_cnt_reg + HW'(1);
                  end else begin
                     frame_next      = build_point_frame(last_pt_reg.f0, last_pt_reg.f1,
                                                         10'd0, 10'd0);
                     frame_kind_next = KIND_BLANK;
                  end
               end
            end
         end
         default: state_next = ST_WAIT;
      endcase
   end

   assign bus.frame        = frame_reg;
   assign bus.frame_bytes  = frame_bytes_reg;
   assign bus.frame_kind   = frame_kind_reg;
   assign bus.blanked      = (frame_kind_reg == KIND_BLANK);
   assign bus.underrun_cnt = underrun_reg;
   assign bus.cfg_ready    = cfg_grant;

endmodule

// File: tb/tb_dds_update_scheduler.sv
// Randomized and directed bench for dds_update_scheduler against a queue-based frame model.
module tb_dds_update_scheduler;

   localparam int DEPTH = 16;
   localparam int MAXC  = 2;
   localparam int HOLDL = 4;

   localparam logic [175:0] RESET_LIT = 176'h00460400000000060010000086040000000006001000;
   localparam logic [175:0] P2_LIT    = 176'h004604ABCD1234060013FF008604FEFE5A5A060010FF;
   localparam logic [175:0] P5_LIT    = 176'h00460411223344060012AA0086045566778806001155;
   localparam logic [175:0] B5_LIT    = 176'h00460411223344060010000086045566778806001000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dds_update_scheduler_if bus ();

   dds_update_scheduler #(
      .FIFO_DEPTH  (DEPTH),
      .MAX_CFG_RUN (MAXC),
      .HOLD_LIMIT  (HOLDL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cr_pulses = 0;

   task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] f0;
      logic [31:0] f1;
      logic [9:0]  a0;
      logic [9:0]  a1;
   } mpt_t;
   typedef logic [7:0] bq_t[$];

   mpt_t         q[$];
   mpt_t         last_pt;
   bit           running;
   int           cfg_run, hold_cnt, underrun;
   logic [175:0] exp_frame;
   int           exp_bytes, exp_kind;
   logic         exp_cr;

   function automatic void add_chan(inout bq_t b, input logic [7:0] csr, input logic [31:0] f,
                                    input logic [9:0] a);
      logic [87:0] v;
      v = {8'h00, csr, 8'h04, f, 8'h06, 8'h00, 6'b000100, a};
      for (int i = 0; i < 11; i++) b.push_back(v[87-8*i -: 8]);
   endfunction

   function automatic logic [175:0] to_frame(input bq_t b);
      logic [175:0] r;
      r = '0;
      for (int i = 0; i < b.size(); i++) r[175-8*i -: 8] = b[i];
      return r;
   endfunction

   function automatic void set_point(input mpt_t p, input int kind);
      bq_t b;
      add_chan(b, 8'h46, p.f0, p.a0);
      add_chan(b, 8'h86, p.f1, p.a1);
      exp_frame = to_frame(b);
      exp_bytes = b.size();
      exp_kind  = kind;
   endfunction

   function automatic void set_cfg(input logic [1:0] ch, input logic [4:0] addr,
                                   input logic [31:0] data, input logic [2:0] nb);
      bq_t b;
      int  n;
      n = (nb == 0 || nb > 4) ? 4 : int'(nb);
      b.push_back(8'h00);
      b.push_back({ch, 6'b000110});
      b.push_back({3'b000, addr});
      for (int i = 0; i < n; i++) b.push_back(data[31-8*i -: 8]);
      exp_frame = to_frame(b);
      exp_bytes = b.size();
      exp_kind  = 2;
   endfunction

   function automatic void model_reset();
      mpt_t z;
      z = '{f0: 32'd0, f1: 32'd0, a0: 10'd0, a1: 10'd0};
      q.delete();
      last_pt  = z;
      running  = 1'b0;
      cfg_run  = 0;
      hold_cnt = 0;
      underrun = 0;
      set_point(z, 0);
   endfunction

   function automatic void model_step();
      mpt_t p, in_pt;
      bit   push;
      push  = bus.pt_valid && (q.size() < DEPTH);
      in_pt = '{f0: bus.pt_f0, f1: bus.pt_f1, a0: bus.pt_a0, a1: bus.pt_a1};
      if (running && bus.slot) begin
         if (bus.cfg_valid && (q.size() == 0 || cfg_run < MAXC)) begin
            set_cfg(bus.cfg_ch, bus.cfg_addr, bus.cfg_data, bus.cfg_nbytes);
            cfg_run++;
         end else if (q.size() > 0) begin
            p = q.pop_front();
            last_pt = p;
            set_point(p, 1);
            cfg_run  = 0;
            hold_cnt = 0;
         end else begin
            if (underrun < 65535) underrun++;
            if (hold_cnt < HOLDL) begin
               set_point(last_pt, 3);
               hold_cnt++;
            end else begin
               p = '{f0: last_pt.f0, f1: last_pt.f1, a0: 10'd0, a1: 10'd0};
               set_point(p, 0);
            end
         end
         $display("[TB] slot t=%0t kind=%0d bytes=%0d fifo=%0d underrun=%0d",
                  $time, exp_kind, exp_bytes, q.size(), underrun);
      end
      if (push) q.push_back(in_pt);
      running = bus.dds_ready;
   endfunction

   // Single compare process: outputs are stable around the falling edge.
   always @(negedge clk) begin
      if (reset) model_reset();
      exp_cr = !reset && running && bus.slot && bus.cfg_valid && (q.size() == 0 || cfg_run < MAXC);
      check("frame", bus.frame, exp_frame);
      check("frame_bytes", 176'(bus.frame_bytes), 176'(exp_bytes));
      check("frame_kind", 176'(bus.frame_kind), 176'(exp_kind));
      check("blanked", 176'(bus.blanked), 176'(exp_kind == 0));
      check("pt_ready", 176'(bus.pt_ready), 176'(q.size() < DEPTH));
      check("cfg_ready", 176'(bus.cfg_ready), 176'(exp_cr));
      check("underrun_cnt", 176'(bus.underrun_cnt), 176'(underrun));
      if (!reset) model_step();
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pt(input logic [31:0] f0, input logic [31:0] f1,
                          input logic [9:0] a0, input logic [9:0] a1);
      bus.pt_valid = 1'b1;
      bus.pt_f0 = f0;
      bus.pt_f1 = f1;
      bus.pt_a0 = a0;
      bus.pt_a1 = a1;
      tick();
      bus.pt_valid = 1'b0;
   endtask

   task automatic push_rand();
      push_pt($urandom, $urandom, 10'($urandom), 10'($urandom));
   endtask

   task automatic do_slot();
      bus.slot = 1'b1;
      #1;
      if (bus.cfg_ready) cr_pulses++;
      tick();
      bus.slot = 1'b0;
   endtask

   initial begin
      bus.dds_ready  = 1'b0;
      bus.slot       = 1'b0;
      bus.pt_valid   = 1'b0;
      bus.pt_f0      = '0;
      bus.pt_f1      = '0;
      bus.pt_a0      = '0;
      bus.pt_a1      = '0;
      bus.cfg_valid  = 1'b0;
      bus.cfg_ch     = '0;
      bus.cfg_addr   = '0;
      bus.cfg_data   = '0;
      bus.cfg_nbytes = '0;
      #1 reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      check("rst_frame", bus.frame, RESET_LIT);
      check("rst_kind", 176'(bus.frame_kind), 176'd0);
      check("rst_bytes", 176'(bus.frame_bytes), 176'd22);
      check("rst_pt_ready", 176'(bus.pt_ready), 176'd1);
      check("rst_blanked", 176'(bus.blanked), 176'd1);

      // WAIT: points buffered, slots ignored
      push_pt(32'hABCD1234, 32'hFEFE5A5A, 10'd1023, 10'd255);
      push_rand();
      push_rand();
      repeat (3) begin
         do_slot();
         check("wait_kind", 176'(bus.frame_kind), 176'd0);
      end
      check("wait_bytes", 176'(bus.frame_bytes), 176'd22);
      check("wait_pt_ready", 176'(bus.pt_ready), 176'd1);

      // RUN: first point frame, then exactly 3 buffered entries
      bus.dds_ready = 1'b1;
      tick();
      do_slot();
      check("pt_frame", bus.frame, P2_LIT);
      check("pt_kind", 176'(bus.frame_kind), 176'd1);
      do_slot();
      do_slot();
      check("third_pt_kind", 176'(bus.frame_kind), 176'd1);
      do_slot();
      check("fourth_hold_kind", 176'(bus.frame_kind), 176'd3);

      // Config run limit with a non-empty FIFO
      repeat (8) push_rand();
      bus.cfg_valid  = 1'b1;
      bus.cfg_ch     = 2'b10;
      bus.cfg_addr   = 5'h03;
      bus.cfg_data   = 32'hCAFEF00D;
      bus.cfg_nbytes = 3'd4;
      cr_pulses = 0;
      do_slot();
      check("run_k0", 176'(bus.frame_kind), 176'd2);
      tick();
      do_slot();
      check("run_k1", 176'(bus.frame_kind), 176'd2);
      tick();
      do_slot();
      check("run_k2", 176'(bus.frame_kind), 176'd1);
      tick();
      do_slot();
      check("run_k3", 176'(bus.frame_kind), 176'd2);
      check("cfg_pulses", 176'(cr_pulses), 176'd3);

      // Short config frame
      bus.cfg_ch     = 2'b01;
      bus.cfg_addr   = 5'h05;
      bus.cfg_data   = 32'h12345678;
      bus.cfg_nbytes = 3'd2;
      do_slot();
      check("cfg_head", 176'(bus.frame[175:136]), 176'h0046051234);
      check("cfg_bytes", 176'(bus.frame_bytes), 176'd5);
      bus.cfg_valid = 1'b0;

      // Randomized traffic: busy stream, then a sparse one
      for (int i = 0; i < 700; i++) begin
         bus.pt_valid   = (i < 350) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
         bus.pt_f0      = $urandom;
         bus.pt_f1      = $urandom;
         bus.pt_a0      = 10'($urandom);
         bus.pt_a1      = 10'($urandom);
         bus.slot       = ($urandom_range(0, 2) == 0);
         bus.cfg_valid  = ($urandom_range(0, 3) == 0);
         bus.cfg_ch     = 2'($urandom);
         bus.cfg_addr   = 5'($urandom);
         bus.cfg_data   = $urandom;
         bus.cfg_nbytes = 3'($urandom);
         if ($urandom_range(0, 59) == 0) bus.dds_ready = ~bus.dds_ready;
         tick();
      end
      bus.pt_valid  = 1'b0;
      bus.slot      = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.dds_ready = 1'b1;

      // Underrun: hold for HOLDL slots, then blank
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push_pt(32'h11223344, 32'h55667788, 10'h2AA, 10'h155);
      do_slot();
      check("ur_point", bus.frame, P5_LIT);
      repeat (HOLDL) begin
         do_slot();
         check("ur_hold_kind", 176'(bus.frame_kind), 176'd3);
         check("ur_hold_frame", bus.frame, P5_LIT);
      end
      do_slot();
      check("ur_blank_kind", 176'(bus.frame_kind), 176'd0);
      check("ur_blank_frame", bus.frame, B5_LIT);
      check("ur_count5", 176'(bus.underrun_cnt), 176'd5);
      do_slot();
      check("ur_count6", 176'(bus.underrun_cnt), 176'd6);
      push_rand();
      do_slot();
      check("ur_resume_kind", 176'(bus.frame_kind), 176'd1);
      check("ur_resume_blanked", 176'(bus.blanked), 176'd0);

      // Full FIFO, refused push during pop, async reset
      repeat (DEPTH) push_rand();
      check("full_pt_ready", 176'(bus.pt_ready), 176'd0);
      bus.pt_valid = 1'b1;
      do_slot();
      bus.pt_valid = 1'b0;
      check("refused_push_ready", 176'(bus.pt_ready), 176'd1);
      bus.slot = 1'b1;
      reset    = 1'b1;
      #1;
      check("async_kind", 176'(bus.frame_kind), 176'd0);
      check("async_underrun", 176'(bus.underrun_cnt), 176'd0);
      check("async_pt_ready", 176'(bus.pt_ready), 176'd1);
      check("async_frame", bus.frame, RESET_LIT);
      bus.slot = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      do_slot();
      check("post_rst_hold", 176'(bus.frame_kind), 176'd3);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
